// File: rtl/weight_arb_pkg.sv
// Shared types and helpers for the weight BRAM arbiter.
// Build option: WEIGHT_ARB_FIXED_PRIO_EN selects fixed priority.
package weight_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int RD_LAT_DEF = 2;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_bram_arbiter_rr_arbiter.sv
// One-hot requester pick, round-robin from ptr or lowest-index first.
// Build option: WEIGHT_ARB_FIXED_PRIO_EN ignores ptr.
module rr_arbiter
  import weight_arb_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = id_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

`ifdef WEIGHT_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IDW'(i);
        any    = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] j;

  // Scan from the far end so the last hit is the first at/after ptr.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IDW'((int'(ptr) + i) % N);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
        any    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/weight_bram_arbiter.sv
// Shares one read-only weight BRAM between NUM_REQ burst loaders.
// Build option: WEIGHT_ARB_FIXED_PRIO_EN swaps round-robin for fixed priority.
module weight_bram_arbiter
  import weight_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int W          = 8,
  parameter  int ADDR_WIDTH = 18,
  parameter  int LEN_W      = 19,
  parameter  int RD_LAT     = RD_LAT_DEF,
  localparam int IDW        = id_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base,
  input  logic [NUM_REQ*LEN_W-1:0]      req_len,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          rd_valid,
  output logic [W-1:0]                  rd_data,
  output logic [IDW-1:0]                rd_id,
  output logic [NUM_REQ-1:0]            burst_done,
  output logic                          bram_en,
  output logic                          bram_ren,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  input  logic [W-1:0]                  bram_dout
);

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    en_q, en_d;
  logic                    ren_q, ren_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [7:0]              drain_q, drain_d;
  logic [IDW-1:0]          id_q, id_d;
  logic [RD_LAT-1:0]       vld_q, vld_d;
  logic [IDW-1:0]          ptr;

  logic [NUM_REQ-1:0]      win_gnt;
  logic [IDW-1:0]          win_idx;
  logic                    win_any;
  logic [ADDR_WIDTH-1:0]   win_base;
  logic [LEN_W-1:0]        win_len;

`ifdef WEIGHT_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IDW-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == DRAIN && drain_q == 8'(RD_LAT - 1)) begin
      ptr_d = (int'(id_q) == NUM_REQ - 1) ? '0 : id_q + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  assign win_base = req_base[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_len  = req_len[int'(win_idx)*LEN_W +: LEN_W];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    en_d    = en_q;
    ren_d   = ren_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    id_d    = id_q;
    vld_d   = (vld_q << 1) | RD_LAT'(ren_q);
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          grant_d = win_gnt;
          id_d    = win_idx;
          if (win_len != '0) begin
            state_d = ISSUE;
            en_d    = 1'b1;
            ren_d   = 1'b1;
            addr_d  = win_base;
            cnt_d   = win_len - LEN_W'(1);
          end else begin
            // Zero-length: one granted cycle that also carries the done pulse.
            state_d = DRAIN;
            drain_d = 8'(RD_LAT - 1);
            done_d  = win_gnt;
          end
        end
      end
      ISSUE: begin
        if (cnt_q == '0) begin
          state_d = DRAIN;
          ren_d   = 1'b0;
          drain_d = '0;
          if (RD_LAT == 1) done_d = grant_q;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q - LEN_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == 8'(RD_LAT - 1)) begin
          state_d = IDLE;
          grant_d = '0;
          en_d    = 1'b0;
        end else begin
          drain_d = drain_q + 8'd1;
          if (RD_LAT >= 2 && drain_q == 8'(RD_LAT - 2)) done_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      en_q    <= 1'b0;
      ren_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      id_q    <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      en_q    <= en_d;
      ren_q   <= ren_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
    end
  end

  assign grant      = grant_q;
  assign burst_done = done_q;
  assign bram_en    = en_q;
  assign bram_ren   = ren_q;
  assign bram_addr  = addr_q;
  assign rd_valid   = vld_q[RD_LAT-1];
  assign rd_data    = rd_valid ? bram_dout : '0;
  assign rd_id      = id_q;

endmodule
